// File: rtl/l1ca_code_sync.sv
// GPS L1 C/A code-phase search: serial correlation of hard chips against a local Gold-code replica, slipping one chip per failed period.
// Latency: corr/corr_valid/locked/lock_lost/search_fail update 1 cycle after the 1023rd chip of a period; search_fail for a bad sv 1 cycle after start.
// Backpressure: none; chip_valid qualifies every chip, idle cycles stall the search without losing state, and every offered chip is consumed.
//
// Ports:
//   clk, rst (sync, active-high), clear (sync abort, same effect as rst)
//   start, sv[5:0] (0..31 = PRN1..PRN32), threshold[9:0]  -- sampled on start in IDLE
//   chip_valid, chip_in                                   -- received chip stream
//   locked, busy, epoch                                   -- status levels
//   corr_valid, corr[10:0] (signed), code_phase[9:0]      -- per-period result
//   search_fail, lock_lost                                -- one-cycle event pulses
module l1ca_code_sync #(
  parameter int MAX_SLIPS = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic [5:0]         sv,
  input  logic               chip_valid,
  input  logic               chip_in,
  input  logic [9:0]         threshold,
  output logic               locked,
  output logic               busy,
  output logic               corr_valid,
  output logic signed [10:0] corr,
  output logic [9:0]         code_phase,
  output logic               epoch,
  output logic               search_fail,
  output logic               lock_lost
);

  typedef enum logic [1:0] {IDLE = 2'd0, CORR = 2'd1, SLIP = 2'd2, LOCKED = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [10:1]        g1, g2;          // bit k is LFSR stage k
  logic [10:1]        g1_nxt, g2_nxt;
  logic [3:0]         tap_a, tap_b;    // G2 stage numbers for the selected PRN
  logic [4:0]         sv_r;
  logic [9:0]         thr_r;
  logic signed [10:0] acc, sum;
  logic [10:0]        sum_abs;
  logic [9:0]         cnt;
  logic [10:0]        slip_cnt;
  logic               rep_chip, accept, period_end, pass, exhausted;

  // G2 phase-selector tap pairs, PRN1..PRN32
  always_comb begin
    {tap_a, tap_b} = {4'd2, 4'd6};
    case (sv_r)
      5'd0:  {tap_a, tap_b} = {4'd2, 4'd6};
      5'd1:  {tap_a, tap_b} = {4'd3, 4'd7};
      5'd2:  {tap_a, tap_b} = {4'd4, 4'd8};
      5'd3:  {tap_a, tap_b} = {4'd5, 4'd9};
      5'd4:  {tap_a, tap_b} = {4'd1, 4'd9};
      5'd5:  {tap_a, tap_b} = {4'd2, 4'd10};
      5'd6:  {tap_a, tap_b} = {4'd1, 4'd8};
      5'd7:  {tap_a, tap_b} = {4'd2, 4'd9};
      5'd8:  {tap_a, tap_b} = {4'd3, 4'd10};
      5'd9:  {tap_a, tap_b} = {4'd2, 4'd3};
      5'd10: {tap_a, tap_b} = {4'd3, 4'd4};
      5'd11: {tap_a, tap_b} = {4'd5, 4'd6};
      5'd12: {tap_a, tap_b} = {4'd6, 4'd7};
      5'd13: {tap_a, tap_b} = {4'd7, 4'd8};
      5'd14: {tap_a, tap_b} = {4'd8, 4'd9};
      5'd15: {tap_a, tap_b} = {4'd9, 4'd10};
      5'd16: {tap_a, tap_b} = {4'd1, 4'd4};
      5'd17: {tap_a, tap_b} = {4'd2, 4'd5};
      5'd18: {tap_a, tap_b} = {4'd3, 4'd6};
      5'd19: {tap_a, tap_b} = {4'd4, 4'd7};
      5'd20: {tap_a, tap_b} = {4'd5, 4'd8};
      5'd21: {tap_a, tap_b} = {4'd6, 4'd9};
      5'd22: {tap_a, tap_b} = {4'd1, 4'd3};
      5'd23: {tap_a, tap_b} = {4'd4, 4'd6};
      5'd24: {tap_a, tap_b} = {4'd5, 4'd7};
      5'd25: {tap_a, tap_b} = {4'd6, 4'd8};
      5'd26: {tap_a, tap_b} = {4'd7, 4'd9};
      5'd27: {tap_a, tap_b} = {4'd8, 4'd10};
      5'd28: {tap_a, tap_b} = {4'd1, 4'd6};
      5'd29: {tap_a, tap_b} = {4'd2, 4'd7};
      5'd30: {tap_a, tap_b} = {4'd3, 4'd8};
      5'd31: {tap_a, tap_b} = {4'd4, 4'd9};
      default: {tap_a, tap_b} = {4'd2, 4'd6};
    endcase
  end

  // G1 = 1 + x^3 + x^10, G2 = 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10
  assign g1_nxt   = {g1[9:1], g1[3] ^ g1[10]};
  assign g2_nxt   = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
  assign rep_chip = g1[10] ^ g2[tap_a] ^ g2[tap_b];

  assign accept     = chip_valid && (state == CORR || state == LOCKED);
  assign sum        = (chip_in == rep_chip) ? acc + 11'sd1 : acc - 11'sd1;
  // sum never reaches -1024, so negating in 11 bits cannot overflow
  assign sum_abs    = sum[10] ? $unsigned(-sum) : $unsigned(sum);
  assign period_end = accept && (cnt == 10'd1022);
  assign pass       = sum_abs >= {1'b0, thr_r};
  assign exhausted  = (slip_cnt == 11'(MAX_SLIPS));

  // state register
  always_ff @(posedge clk) begin
    if (rst || clear) state <= IDLE;
    else              state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (start && !sv[5]) state_nxt = CORR;
      CORR, LOCKED: begin
        if (period_end) begin
          if (pass)           state_nxt = LOCKED;
          else if (exhausted) state_nxt = IDLE;
          else                state_nxt = SLIP;
        end
      end
      SLIP:        if (chip_valid) state_nxt = CORR;
      default:     state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    locked = (state == LOCKED);
    busy   = (state != IDLE);
    epoch  = &g1;
  end

  // replica, accumulator, counters and event pulses
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      g1          <= '1;
      g2          <= '1;
      acc         <= '0;
      cnt         <= '0;
      slip_cnt    <= '0;
      sv_r        <= '0;
      thr_r       <= '0;
      corr        <= '0;
      corr_valid  <= 1'b0;
      code_phase  <= '0;
      search_fail <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      corr_valid  <= 1'b0;
      search_fail <= 1'b0;
      lock_lost   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (sv[5]) begin
              search_fail <= 1'b1;
            end else begin
              sv_r       <= sv[4:0];
              thr_r      <= threshold;
              g1         <= '1;
              g2         <= '1;
              acc        <= '0;
              cnt        <= '0;
              slip_cnt   <= '0;
              code_phase <= '0;
            end
          end
        end
        CORR, LOCKED: begin
          if (chip_valid) begin
            g1 <= g1_nxt;
            g2 <= g2_nxt;
            if (cnt == 10'd1022) begin
              // period boundary: the replica wraps to chip 0 on this same advance
              corr       <= sum;
              corr_valid <= 1'b1;
              acc        <= '0;
              cnt        <= '0;
              if (!pass) begin
                lock_lost   <= (state == LOCKED);
                search_fail <= exhausted;
              end
            end else begin
              acc <= sum;
              cnt <= cnt + 10'd1;
            end
          end
        end
        SLIP: begin
          // swallow one input chip with the replica held: replica falls one chip behind
          if (chip_valid) begin
            code_phase <= (code_phase == 10'd1022) ? 10'd0 : code_phase + 10'd1;
            slip_cnt   <= slip_cnt + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l1ca_code_sync.sv
// Bench for l1ca_code_sync: drives PRN chip streams, predicts each period result in a scoreboard queue.
// Latency: checks results as corr_valid pulses; directed checks for reset, bad sv and boundaries.
// Backpressure: none; optional random chip_valid gaps.
module tb_l1ca_code_sync;

  localparam int MAXS = 8;
  localparam int BIG  = 1 << 30;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               clear = 1'b0;
  logic [5:0]         sv = '0;
  logic               chip_valid = 1'b0;
  logic               chip_in = 1'b0;
  logic [9:0]         threshold = '0;
  logic               locked, busy, corr_valid, epoch, search_fail, lock_lost;
  logic signed [10:0] corr;
  logic [9:0]         code_phase;

  l1ca_code_sync #(.MAX_SLIPS(MAXS)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .sv(sv),
    .chip_valid(chip_valid), .chip_in(chip_in), .threshold(threshold),
    .locked(locked), .busy(busy), .corr_valid(corr_valid), .corr(corr),
    .code_phase(code_phase), .epoch(epoch), .search_fail(search_fail),
    .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int corr;
    int lk;
    int ph;
    int lost;
    int fail;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   code1[1023];
  bit   code2[1023];
  int   n_chk = 0;
  int   n_err = 0;

  // reference model state: 0 idle, 1 corr, 2 slip, 3 locked
  int m_state = 0, m_cnt = 0, m_acc = 0, m_slips = 0, m_phase = 0, m_thr = 0, m_sv = 0;

  task automatic check(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic gen_code(int ta, int tb, int which);
    bit g1[1:10];
    bit g2[1:10];
    bit c, f1, f2;
    for (int k = 1; k <= 10; k++) begin g1[k] = 1'b1; g2[k] = 1'b1; end
    for (int i = 0; i < 1023; i++) begin
      c = g1[10] ^ g2[ta] ^ g2[tb];
      if (which == 1) code1[i] = c; else code2[i] = c;
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int k = 10; k >= 2; k--) begin g1[k] = g1[k-1]; g2[k] = g2[k-1]; end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  function automatic bit prn_chip(int prn, int idx);
    return (prn == 1) ? code1[idx] : code2[idx];
  endfunction

  task automatic model_start(int s, int thr);
    if (m_state == 0 && s <= 31) begin
      m_state = 1; m_cnt = 0; m_acc = 0; m_slips = 0; m_phase = 0;
      m_thr = thr; m_sv = s;
    end
  endtask

  task automatic model_chip(bit x);
    exp_t e;
    int   a;
    bit   r;
    if (m_state == 2) begin
      m_slips++;
      m_phase = (m_phase + 1) % 1023;
      m_state = 1;
    end else if (m_state == 1 || m_state == 3) begin
      r = (m_sv == 0) ? code1[m_cnt] : code2[m_cnt];
      m_acc += (x == r) ? 1 : -1;
      m_cnt++;
      if (m_cnt == 1023) begin
        a      = (m_acc < 0) ? -m_acc : m_acc;
        e.corr = m_acc;
        e.lk   = (a >= m_thr) ? 1 : 0;
        e.ph   = m_phase;
        e.lost = (e.lk == 0 && m_state == 3) ? 1 : 0;
        e.fail = (e.lk == 0 && m_slips == MAXS) ? 1 : 0;
        m_state = (e.lk == 1) ? 3 : ((e.fail == 1) ? 0 : 2);
        q.push_back(e);
        m_acc = 0;
        m_cnt = 0;
      end
    end
  endtask

  // scoreboard: one queued prediction per corr_valid pulse
  always @(negedge clk) begin
    if (corr_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("spurious_corr_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("corr", corr, mon_e.corr);
        check("locked_at_cv", locked, mon_e.lk);
        check("code_phase_at_cv", code_phase, mon_e.ph);
        check("lock_lost_at_cv", lock_lost, mon_e.lost);
        check("search_fail_at_cv", search_fail, mon_e.fail);
      end
    end
  end

  task automatic do_start(int s, int thr);
    @(negedge clk);
    start = 1'b1; sv = 6'(s); threshold = 10'(thr); chip_valid = 1'b0;
    model_start(s, thr);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(int prn, int d, bit inv, int zero_from, int t0, int n, int gap);
    bit x;
    int idx;
    for (int t = t0; t < t0 + n; t++) begin
      for (int g = 0; g < 3 && (int'($urandom_range(99)) < gap); g++) begin
        @(negedge clk);
        chip_valid = 1'b0;
        chip_in    = 1'($urandom_range(1));
      end
      idx = ((t - d) % 1023 + 1023) % 1023;
      x   = (t >= zero_from) ? 1'b0 : (prn_chip(prn, idx) ^ inv);
      @(negedge clk);
      start = 1'b0; chip_valid = 1'b1; chip_in = x;
      model_chip(x);
    end
    @(negedge clk);
    chip_valid = 1'b0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_drain"}, q.size(), 0);
  endtask

  // reset/clear asserted together with start and chip_valid: the abort must win
  task automatic do_reset(bit use_clear, string tag);
    @(negedge clk);
    check({tag, "_no_pending"}, q.size(), 0);
    if (use_clear) clear = 1'b1; else rst = 1'b1;
    start = 1'b1; chip_valid = 1'b1; sv = '0; threshold = '0;
    m_state = 0; m_cnt = 0; m_acc = 0;
    @(negedge clk);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_corr_valid"}, corr_valid, 0);
    check({tag, "_corr"}, corr, 0);
    check({tag, "_code_phase"}, code_phase, 0);
    check({tag, "_search_fail"}, search_fail, 0);
    check({tag, "_lock_lost"}, lock_lost, 0);
    check({tag, "_epoch"}, epoch, 1);
    rst = 1'b0; clear = 1'b0; start = 1'b0; chip_valid = 1'b0;
    @(negedge clk);
    check({tag, "_exit_cv"}, corr_valid, 0);
    check({tag, "_exit_fail"}, search_fail, 0);
    check({tag, "_exit_lost"}, lock_lost, 0);
    check({tag, "_exit_busy"}, busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    gen_code(2, 6, 1);
    gen_code(3, 7, 2);
    repeat (2) @(negedge clk);
    do_reset(1'b0, "por");

    // aligned PRN1: lock on the first period, start while locked is ignored
    do_start(0, 800);
    check("start_busy", busy, 1);
    check("start_epoch", epoch, 1);
    run(1, 0, 1'b0, BIG, 0, 10, 0);
    check("epoch_mid_period", epoch, 0);
    run(1, 0, 1'b0, BIG, 10, 1013, 0);
    do_start(1, 0);
    run(1, 0, 1'b0, BIG, 1023, 1023, 0);
    drain("aligned");
    check("aligned_still_locked", locked, 1);
    do_reset(1'b1, "clear_locked");

    // 5-chip delay: five slips then lock on the sixth period
    do_start(0, 800);
    run(1, 5, 1'b0, BIG, 0, 6 * 1023 + 5 + 100, 0);
    drain("delay5");
    check("delay5_phase", code_phase, 5);
    check("delay5_locked", locked, 1);
    do_reset(1'b0, "rst_locked");

    // abort mid-CORR, then a fresh start relocks
    do_start(0, 800);
    run(1, 0, 1'b0, BIG, 0, 500, 0);
    do_reset(1'b1, "clear_corr");
    do_start(0, 800);
    run(1, 0, 1'b0, BIG, 0, 400, 0);
    do_reset(1'b0, "rst_corr");
    do_start(0, 800);
    run(1, 0, 1'b0, BIG, 0, 1023, 0);
    drain("relock");
    do_reset(1'b0, "rst_relock");

    // data-bit inversion locks through |corr|
    do_start(0, 800);
    run(1, 0, 1'b1, BIG, 0, 1023, 0);
    drain("inverted");
    do_reset(1'b0, "rst_inv");

    // threshold boundaries: 1023 still locks aligned, 0 locks any period
    do_start(0, 1023);
    run(1, 0, 1'b0, BIG, 0, 1023, 0);
    drain("thr_max");
    do_reset(1'b1, "clear_thrmax");
    do_start(0, 0);
    run(2, 0, 1'b0, BIG, 0, 1023, 0);
    drain("thr_zero");
    do_reset(1'b0, "rst_thr0");

    // wrong PRN: exhaust the slip budget
    do_start(0, 800);
    run(2, 0, 1'b0, BIG, 0, (MAXS + 1) * 1023 + MAXS, 0);
    drain("exhaust");
    check("exhaust_busy", busy, 0);
    check("exhaust_phase", code_phase, MAXS);

    // invalid sv: fail pulse, no search
    do_start(40, 800);
    check("badsv_fail", search_fail, 1);
    check("badsv_busy", busy, 0);
    @(negedge clk);
    check("badsv_fail_pulse", search_fail, 0);
    check("badsv_busy2", busy, 0);

    // lock loss when the signal vanishes, without and with chip_valid gaps
    do_start(0, 800);
    run(1, 0, 1'b0, 2046, 0, 4 * 1023 + 1, 0);
    drain("loss");
    do_reset(1'b1, "clear_loss");
    do_start(0, 800);
    run(1, 0, 1'b0, 2046, 0, 4 * 1023 + 1, 30);
    drain("loss_gaps");
    do_reset(1'b0, "rst_loss_gaps");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/l1ca_code_sync.md
L1CA_CODE_SYNC -- requirements
Module: l1ca_code_sync

Interface
REQ-001 SHALL expose: clk  in  1  single system clock; all logic on posedge.
REQ-002 SHALL expose: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL expose: start  in  1  pulse; begins search when IDLE, ignored otherwise.
REQ-004 SHALL expose: clear  in  1  synchronous abort; same effect as rst.
REQ-005 SHALL expose: sv  in  6 (sv_t)  satellite index 0..31 = PRN1..PRN32; sampled on start.
REQ-006 SHALL expose: chip_valid  in  1  one received chip present this cycle.
REQ-007 SHALL expose: chip_in  in  1  received hard-decision chip.
REQ-008 SHALL expose: threshold  in  10  unsigned lock threshold on |correlation|; sampled on start.
REQ-009 SHALL expose: locked  out  1  replica aligned to input.
REQ-010 SHALL expose: busy  out  1  state != IDLE.
REQ-011 SHALL expose: corr_valid  out  1  one-cycle pulse, corr updated.
REQ-012 SHALL expose: corr  out  11 signed  correlation of last completed period, range -1023..+1023.
REQ-013 SHALL expose: code_phase  out  10 (gps_chip_t)  accumulated replica slips mod 1023.
REQ-014 SHALL expose: epoch  out  1  local replica G1 register all ones (replica chip 0).
REQ-015 SHALL expose: search_fail  out  1  one-cycle pulse, search exhausted or sv invalid.
REQ-016 SHALL expose: lock_lost  out  1  one-cycle pulse, lock dropped.

Function
REQ-017 Local replica SHALL be G1 (x^10+x^3+1) and G2 (x^10+x^9+x^8+x^6+x^3+x^2+1), both all ones at search start, output G1[10] xor the IS-GPS-200 G2 tap pair for sv.
REQ-018 FSM states SHALL be IDLE, CORR, SLIP, LOCKED.
REQ-019 IDLE: start with sv<=31 -> CORR with LFSRs all ones, accumulator 0, period counter 0, code_phase 0; start with sv>31 -> search_fail pulse next cycle, stay IDLE.
REQ-020 CORR/LOCKED: each chip_valid cycle SHALL add +1 if chip_in == replica chip else -1, advance replica one chip, increment period counter; no chip_valid -> no change.
REQ-021 On the cycle the 1023rd chip is accepted, the sum including that chip SHALL be registered to corr, corr_valid pulses the next cycle, accumulator and counter reset; no input chip is lost.
REQ-022 End of period in CORR: |sum| >= threshold -> LOCKED (locked=1 with corr_valid); else -> SLIP.
REQ-023 End of period in LOCKED: |sum| >= threshold -> stay LOCKED; else locked=0, lock_lost pulse, -> SLIP.
REQ-024 SLIP: next chip_valid cycle SHALL be consumed without advancing replica or accumulating, code_phase increments mod 1023 (1022 -> 0), then -> CORR.
REQ-025 Slip counter SHALL count slips since start; entering SLIP with 1023 slips already taken -> search_fail pulse, -> IDLE.
REQ-026 Negative correlation (data-bit inversion) SHALL count as lock via |sum|; |-1023| computed without overflow.
REQ-027 threshold=0 SHALL lock at first period end.
REQ-028 start during non-IDLE SHALL be ignored; clear SHALL override start and chip_valid in the same cycle.
REQ-029 epoch SHALL be combinational from G1 state, valid in all states.

Reset
REQ-030 On rst or clear, next cycle: state IDLE, locked=0, busy=0, corr_valid=0, corr=0, code_phase=0, search_fail=0, lock_lost=0, LFSRs all ones, accumulator and counters 0.
REQ-031 rst mid-search SHALL discard partial correlation; no pulse outputs on reset exit.

Verification
REQ-032 sv=0, threshold=800, input = PRN1 from chip 0, chip_valid every cycle -> first corr_valid with corr=+1023, locked=1, code_phase=0.
REQ-033 Same input delayed 5 chips -> five corr_valid with |corr|<800, lock on sixth period, code_phase=5, corr=+1023.
REQ-034 Inverted PRN1 aligned -> corr=-1023, locked=1.
REQ-035 PRN2 input, sv=0, threshold=800 -> never locks; search_fail after 1023 slips; busy=0; sv=40 start -> search_fail, no search.
REQ-036 Locked on PRN1, input switched to constant 0 -> next period corr far below threshold, lock_lost pulse, locked=0, SLIP entered; chip_valid gaps -> identical results.
REQ-037 rst or clear asserted mid-CORR and in LOCKED -> all outputs at REQ-030 values next cycle; fresh start relocks as REQ-032.
